// File: rtl/alu_issue_ctrl_if.sv
// Instruction-fetch handshake and data-memory bus of the issue controller.
//   instr / instr_pc / instr_valid / instr_ready : byte stream from fetch
//   mem_req / mem_we / mem_addr / mem_wdata      : request towards memory
//   mem_rdata / mem_ack                          : memory response
// master = environment side (fetch + memory), slave = alu_issue_ctrl.
interface alu_issue_ctrl_if;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;

  modport master (
    output instr, instr_pc, instr_valid, mem_rdata, mem_ack,
    input  instr_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  instr, instr_pc, instr_valid, mem_rdata, mem_ack,
    output instr_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Decode/issue controller for the 8-bit CPU, upstream of the ALU.
// Holds the 4x8 register file, sequences ALU ops (EXEC), loads/stores (MEM),
// LoadIMM second byte (IMM), I/O and branch redirects.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   bus (slave)         : instruction handshake + memory bus
//   alu_mode/s1/s2      : ALU control and operands (mode 0 outside EXEC)
//   alu_result, alu_zn  : combinational ALU response
//   flags_zn            : latched {Z,N}
//   in_port, out_port   : I/O; out_strobe pulses when out_port updates
//   mem_err             : sticky memory-timeout flag
//   redirect_valid/target : one-cycle branch redirect to fetch
module alu_issue_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15  // 0 disables the timeout; must fit 16 bits
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_issue_ctrl_if.slave        bus,
  output logic [3:0]             alu_mode,
  output logic [7:0]             alu_s1,
  output logic [7:0]             alu_s2,
  input  logic [7:0]             alu_result,
  input  logic [1:0]             alu_zn,
  output logic [1:0]             flags_zn,
  input  logic [7:0]             in_port,
  output logic [7:0]             out_port,
  output logic                   out_strobe,
  output logic                   mem_err,
  output logic                   redirect_valid,
  output logic [7:0]             redirect_target
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_IMM} state_t;

  localparam bit          TMO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  rf_q [4];
  logic [7:0]  ir_q;
  logic [1:0]  flags_q;
  logic [7:0]  link_q;
  logic [7:0]  out_q;
  logic        out_strobe_q;
  logic        mem_err_q;
  logic        redirect_valid_q;
  logic [7:0]  redirect_target_q;
  logic [15:0] tmo_q;

  logic [3:0]  op_q;
  logic [1:0]  ra_q, rb_q;
  logic [3:0]  in_op;
  logic [1:0]  in_ra, in_rb;
  logic        br_taken;
  logic [7:0]  br_target;

  assign op_q  = ir_q[7:4];
  assign ra_q  = ir_q[3:2];
  assign rb_q  = ir_q[1:0];
  assign in_op = bus.instr[7:4];
  assign in_ra = bus.instr[3:2];
  assign in_rb = bus.instr[1:0];

  // Branch decision straight off the incoming byte, so the redirect is
  // registered at the acceptance edge.
  always_comb begin
    br_taken  = 1'b0;
    br_target = rf_q[in_rb];
    unique case (in_op)
      4'h9, 4'hB: br_taken = 1'b1;
      4'hA:       br_taken = in_ra[0] ? flags_q[0] : flags_q[1];
      4'hC: begin
        br_taken  = 1'b1;
        br_target = link_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_FETCH;
      for (int unsigned i = 0; i < 4; i++) rf_q[i] <= '0;
      ir_q              <= '0;
      flags_q           <= '0;
      link_q            <= '0;
      out_q             <= '0;
      out_strobe_q      <= 1'b0;
      mem_err_q         <= 1'b0;
      redirect_valid_q  <= 1'b0;
      redirect_target_q <= '0;
      tmo_q             <= '0;
    end else begin
      out_strobe_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      unique case (state_q)
        S_FETCH: begin
          if (bus.instr_valid) begin
            ir_q <= bus.instr;
            unique case (in_op)
              4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: state_q <= S_EXEC;
              4'hD, 4'hE: begin
                state_q <= S_MEM;
                tmo_q   <= '0;
              end
              4'hF: state_q <= S_IMM;
              4'h9, 4'hA, 4'hB, 4'hC: begin
                redirect_valid_q  <= br_taken;
                redirect_target_q <= br_target;
                if (in_op == 4'hB) link_q <= bus.instr_pc + 8'd1;
              end
              default: ;
            endcase
          end
        end
        S_EXEC: begin
          unique case (op_q)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
              rf_q[ra_q] <= alu_result;
              flags_q    <= alu_zn;
            end
            4'h7, 4'h8: rf_q[ra_q] <= alu_result;
            4'h6: begin
              out_q        <= alu_result;
              out_strobe_q <= 1'b1;
            end
            default: ;
          endcase
          state_q <= S_FETCH;
        end
        S_MEM: begin
          // An ack in the last allowed cycle still completes the access.
          if (bus.mem_ack) begin
            if (op_q == 4'hD) rf_q[ra_q] <= bus.mem_rdata;
            state_q <= S_FETCH;
          end else if (TMO_EN) begin
            if (tmo_q == TMO_LAST) begin
              mem_err_q <= 1'b1;
              state_q   <= S_FETCH;
            end else begin
              tmo_q <= tmo_q + 16'd1;
            end
          end
        end
        S_IMM: begin
          if (bus.instr_valid) begin
            rf_q[ra_q] <= bus.instr;
            state_q    <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign bus.instr_ready = rst_n && (state_q == S_FETCH || state_q == S_IMM);
  assign bus.mem_req     = (state_q == S_MEM);
  assign bus.mem_we      = (op_q == 4'hE);
  assign bus.mem_addr    = rf_q[rb_q];
  assign bus.mem_wdata   = rf_q[ra_q];

  assign alu_mode        = (state_q == S_EXEC) ? op_q : '0;
  assign alu_s1          = (op_q == 4'h7) ? in_port : rf_q[ra_q];
  assign alu_s2          = rf_q[rb_q];

  assign flags_zn        = flags_q;
  assign out_port        = out_q;
  assign out_strobe      = out_strobe_q;
  assign mem_err         = mem_err_q;
  assign redirect_valid  = redirect_valid_q;
  assign redirect_target = redirect_target_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  localparam int unsigned TMO = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] alu_mode;
  logic [7:0] alu_s1, alu_s2, alu_result, in_port, out_port, redirect_target;
  logic [1:0] alu_zn, flags_zn;
  logic       out_strobe, mem_err, redirect_valid;

  alu_issue_ctrl_if bus();

  alu_issue_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_mode(alu_mode), .alu_s1(alu_s1), .alu_s2(alu_s2),
    .alu_result(alu_result), .alu_zn(alu_zn), .flags_zn(flags_zn),
    .in_port(in_port), .out_port(out_port), .out_strobe(out_strobe),
    .mem_err(mem_err), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stand-in ALU: bit0 of zn is the carry for ADD, the sign otherwise.
  function automatic logic [9:0] alu_f(input logic [3:0] m, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] res;
    s = {1'b0, a} + {1'b0, b};
    case (m)
      4'd1: res = s[7:0];
      4'd2: res = a - b;
      4'd3: res = a & b;
      4'd4: res = a | b;
      4'd5: res = a ^ b;
      4'd6, 4'd7: res = a;
      4'd8: res = b;
      default: res = 8'h00;
    endcase
    return {res == 8'h00, (m == 4'd1) ? s[8] : res[7], res};
  endfunction

  always_comb {alu_zn, alu_result} = alu_f(alu_mode, alu_s1, alu_s2);

  // Memory responder: ack in the ack_delay-th request cycle (0 = never),
  // random stray acks while idle.
  int unsigned ack_delay = 1;
  int unsigned req_cyc = 0;
  int unsigned last_len = 0;
  always @(negedge clk) begin
    bus.mem_rdata = 8'($urandom);
    if (bus.mem_req) begin
      req_cyc++;
      bus.mem_ack = (ack_delay != 0) && (req_cyc == ack_delay);
    end else begin
      if (req_cyc != 0) last_len = req_cyc;
      req_cyc = 0;
      bus.mem_ack = ($urandom_range(0, 3) == 0);
    end
  end

  // Architectural model: register file, flags, link, I/O, plus the one
  // instruction currently outstanding and how long it has been waiting.
  typedef enum {K_IDLE, K_ALU, K_MEM, K_IMM} kind_t;
  kind_t       m_kind = K_IDLE;
  logic [7:0]  m_reg [4];
  logic [3:0]  m_op;
  logic [1:0]  m_ra, m_rb, m_flags;
  logic [7:0]  m_link, m_out, m_target;
  logic        m_err, m_strobe, m_redir;
  int unsigned m_wait;
  logic [9:0]  m_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
      m_flags = 2'b00; m_link = 8'h00; m_out = 8'h00; m_err = 1'b0;
      m_strobe = 1'b0; m_redir = 1'b0; m_target = 8'h00;
      m_kind = K_IDLE; m_wait = 0; m_op = 4'h0; m_ra = 2'd0; m_rb = 2'd0;
    end else begin
      m_strobe = 1'b0;
      m_redir  = 1'b0;
      case (m_kind)
        K_IDLE: if (bus.instr_valid) begin
          m_op = bus.instr[7:4]; m_ra = bus.instr[3:2]; m_rb = bus.instr[1:0];
          if (m_op >= 4'd1 && m_op <= 4'd8) m_kind = K_ALU;
          else if (m_op == 4'hD || m_op == 4'hE) begin m_kind = K_MEM; m_wait = 0; end
          else if (m_op == 4'hF) m_kind = K_IMM;
          else if (m_op == 4'h9) begin m_redir = 1'b1; m_target = m_reg[m_rb]; end
          else if (m_op == 4'hA) begin
            m_redir = m_ra[0] ? m_flags[0] : m_flags[1];
            m_target = m_reg[m_rb];
          end else if (m_op == 4'hB) begin
            m_redir = 1'b1; m_target = m_reg[m_rb];
            m_link = 8'(bus.instr_pc + 8'd1);
          end else if (m_op == 4'hC) begin m_redir = 1'b1; m_target = m_link; end
        end
        K_ALU: begin
          m_r = alu_f(m_op, (m_op == 4'd7) ? in_port : m_reg[m_ra], m_reg[m_rb]);
          if (m_op == 4'd6) begin m_out = m_r[7:0]; m_strobe = 1'b1; end
          else m_reg[m_ra] = m_r[7:0];
          if (m_op <= 4'd5) m_flags = m_r[9:8];
          m_kind = K_IDLE;
        end
        K_MEM: begin
          if (bus.mem_ack) begin
            if (m_op == 4'hD) m_reg[m_ra] = bus.mem_rdata;
            m_kind = K_IDLE;
          end else begin
            m_wait++;
            if (TMO != 0 && m_wait == TMO) begin m_err = 1'b1; m_kind = K_IDLE; end
          end
        end
        K_IMM: if (bus.instr_valid) begin
          m_reg[m_ra] = bus.instr;
          m_kind = K_IDLE;
        end
        default: m_kind = K_IDLE;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    chk("instr_ready", bus.instr_ready, rst_n && (m_kind == K_IDLE || m_kind == K_IMM));
    chk("alu_mode", alu_mode, (m_kind == K_ALU) ? m_op : 4'h0);
    if (m_kind == K_ALU) begin
      chk("alu_s1", alu_s1, (m_op == 4'd7) ? in_port : m_reg[m_ra]);
      chk("alu_s2", alu_s2, m_reg[m_rb]);
    end
    chk("mem_req", bus.mem_req, m_kind == K_MEM);
    if (m_kind == K_MEM) begin
      chk("mem_we", bus.mem_we, m_op == 4'hE);
      chk("mem_addr", bus.mem_addr, m_reg[m_rb]);
      chk("mem_wdata", bus.mem_wdata, m_reg[m_ra]);
    end
    chk("flags_zn", flags_zn, m_flags);
    chk("out_port", out_port, m_out);
    chk("out_strobe", out_strobe, m_strobe);
    chk("mem_err", mem_err, m_err);
    chk("redirect_valid", redirect_valid, m_redir);
    if (m_redir) chk("redirect_target", redirect_target, m_target);
  end

  // Present a byte and hold it until accepted; returns at the negedge
  // right after the accepting clock edge.
  task automatic issue(input logic [7:0] b, input logic [7:0] pc);
    logic r;
    int n;
    n = 0;
    bus.instr = b; bus.instr_pc = pc; bus.instr_valid = 1'b1;
    forever begin
      r = bus.instr_ready;
      @(negedge clk);
      if (r) break;
      n++;
      if (n > 100) begin
        n_tests++; n_fail++;
        $display("FAIL issue_timeout: byte %0h not accepted in 100 cycles", b);
        break;
      end
    end
    bus.instr_valid = 1'b0;
    bus.instr = 8'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr = 8'h00; bus.instr_pc = 8'h00; bus.instr_valid = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00; in_port = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_ready", bus.instr_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // LoadIMM R1=05, R2=FB; ADD R1,R2
    issue(8'hF4, 8'h00); issue(8'h05, 8'h01);
    issue(8'hF8, 8'h02); issue(8'hFB, 8'h03);
    issue(8'h16, 8'h04);
    chk("add_mode", alu_mode, 4'h1);
    chk("add_s1", alu_s1, 8'h05);
    chk("add_s2", alu_s2, 8'hFB);
    @(negedge clk);
    chk("add_flags", flags_zn, 2'b11);
    chk("add_r1_model", m_reg[1], 8'h00);

    // OUT R1 with R1=3C, then IN R3 and OUT R3
    issue(8'hF4, 8'h05); issue(8'h3C, 8'h06);
    issue(8'h64, 8'h07);
    @(negedge clk);
    chk("out_port", out_port, 8'h3C);
    chk("out_strobe_hi", out_strobe, 1'b1);
    @(negedge clk);
    chk("out_strobe_lo", out_strobe, 1'b0);
    in_port = 8'hA5;
    issue(8'h7C, 8'h08);
    issue(8'h6C, 8'h09);
    @(negedge clk);
    chk("in_r3", out_port, 8'hA5);

    // Store with ack on 3rd cycle, then load with no ack
    ack_delay = 3;
    issue(8'hE1, 8'h0A);
    issue(8'h00, 8'h0B);
    repeat (2) @(negedge clk);
    chk("store_req_len", last_len, 3);
    ack_delay = 0;
    issue(8'hD9, 8'h0C);
    issue(8'h00, 8'h0D);
    repeat (2) @(negedge clk);
    chk("load_tmo_len", last_len, TMO);
    chk("mem_err", mem_err, 1'b1);
    issue(8'h68, 8'h0E);
    @(negedge clk);
    chk("load_tmo_r2", out_port, 8'hFB);

    // BR.SUB at FF then RETURN wraps the link to 00
    issue(8'hF8, 8'h10); issue(8'h40, 8'h11);
    issue(8'hB2, 8'hFF);
    chk("brsub_valid", redirect_valid, 1'b1);
    chk("brsub_target", redirect_target, 8'h40);
    issue(8'hC0, 8'h40);
    chk("ret_valid", redirect_valid, 1'b1);
    chk("ret_target", redirect_target, 8'h00);

    // flags 01 via SUB 01-02, then conditional branches
    issue(8'hF4, 8'h20); issue(8'h01, 8'h21);
    issue(8'hF8, 8'h22); issue(8'h02, 8'h23);
    issue(8'h26, 8'h24);
    issue(8'hA0, 8'h25);
    chk("bzn_flags", flags_zn, 2'b01);
    chk("bzn_not_taken", redirect_valid, 1'b0);
    issue(8'hA4, 8'h26);
    chk("bzn_taken", redirect_valid, 1'b1);

    // Reset mid-MEM
    ack_delay = 0;
    issue(8'hD1, 8'h30);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_ready", bus.instr_ready, 1'b0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    // Reset mid-IMM: the next byte must decode as an opcode
    issue(8'hF4, 8'h31);
    #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mem_err", mem_err, 1'b0);
    issue(8'h90, 8'h32);
    chk("post_rst_branch", redirect_valid, 1'b1);
    chk("post_rst_target", redirect_target, 8'h00);

    // Randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      ack_delay = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
      in_port = 8'($urandom);
      issue(8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    ack_delay = 1;
    issue(8'h00, 8'h00);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Decode/issue controller for the 8-bit CPU; sits upstream of the ALU.
- Accepts instruction bytes over a valid/ready handshake and decodes opcode[7:4], ra[3:2], rb[1:0].
- Holds the 4x8 register file and drives the ALU mode and operands, then writes back the ALU result and latches Z/N flags.
- Sequences the non-ALU opcodes: memory access, LoadIMM second byte, I/O, and branch redirect.

Parameters:
- MEM_TIMEOUT, 15: max cycles waiting for mem_ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  8  instruction byte, or the immediate byte for LoadIMM.
- instr_pc  in  8  address of the current instr byte.
- instr_valid  in  1  instr/instr_pc valid.
- instr_ready  out  1  block accepts instr this cycle.
- alu_mode  out  4  ALU mode; 0 when not in EXEC.
- alu_s1  out  8  ALU operand 1.
- alu_s2  out  8  ALU operand 2.
- alu_result  in  8  ALU combinational result.
- alu_zn  in  2  ALU {Z,N}.
- flags_zn  out  2  latched {Z,N}.
- in_port  in  8  external input for IN.
- out_port  out  8  registered output for OUT.
- out_strobe  out  1  one-cycle pulse when out_port updates.
- mem_req  out  1  memory request.
- mem_we  out  1  1=store, 0=load.
- mem_addr  out  8  memory address = R[rb].
- mem_wdata  out  8  store data = R[ra].
- mem_rdata  in  8  load data, valid with mem_ack.
- mem_ack  in  1  memory completion.
- mem_err  out  1  sticky timeout flag.
- redirect_valid  out  1  one-cycle pulse: fetch must jump.
- redirect_target  out  8  jump target.

Behaviour:
- Reset (async, rst_n=0): R0..R3=0, flags_zn=00, link=0, out_port=0, mem_err=0, state=FETCH. All pulses, mem_req and alu_mode are 0. instr_ready=0 while rst_n=0. Reset in any state abandons the operation: mem_req drops immediately and no writeback occurs.
- States: FETCH, EXEC, MEM, IMM.
- FETCH: instr_ready=1. On instr_valid, IR<=instr and PCR<=instr_pc. Opcodes 1-8 -> EXEC; d,e -> MEM; f -> IMM; 9-c -> resolve branch, stay in FETCH; 0 -> NOP, stay in FETCH.
- EXEC (exactly 1 cycle):
  - alu_mode=IR[7:4]; alu_s1=R[ra], except IN uses alu_s1=in_port; alu_s2=R[rb].
  - At the clock edge ending EXEC: modes 1-5, 7 and 8 write R[ra]<=alu_result.
  - Modes 1-5 also update flags_zn<=alu_zn.
  - Mode 6 (OUT) updates out_port<=alu_result and pulses out_strobe in the following cycle; no register write.
  - Next state is FETCH.
- Throughput for ALU ops: 1 instruction per 2 cycles.
- Branches are resolved in the acceptance cycle; redirect_valid pulses the next cycle.
  - BR (9): target=R[rb].
  - BR.Z/N (a): condition is flags_zn[1] if ra[0]=0, else flags_zn[0]. Not taken means no pulse.
  - BR.SUB (b): target=R[rb]; link<=instr_pc+1 (mod 256).
  - RETURN (c): target=link.
  - Back-to-back branches are legal.
- MEM (Load d / Store e):
  - mem_req=1 with mem_addr and mem_wdata held stable; mem_we=(op==e).
  - On mem_ack: a load writes R[ra]<=mem_rdata; mem_req drops in the same edge; next state is FETCH.
  - Flags are unchanged by loads and stores.
  - Timeout: counter starts at 0 on MEM entry. After MEM_TIMEOUT cycles without ack: set mem_err, drop mem_req, no writeback, return to FETCH.
  - mem_ack outside MEM is ignored.
- IMM: instr_ready=1. The next accepted byte is written to R[ra] of IR and is not decoded; return to FETCH. Flags are unchanged.
- Width rules: all arithmetic is 8-bit and wraps; the link increment wraps from 0xFF to 0x00.
- Register hazards: none. Reads in EXEC/MEM see the writes of all prior instructions.

Test Plan:
- Reset, then LoadIMM R1 (0xF4, then 0x05) and LoadIMM R2 (0xF8, then 0xFB). Then ADD R1,R2 (0x16) -> alu_mode=1 with s1=0x05, s2=0xFB in EXEC; R1=0x00; flags_zn=2'b11.
- OUT R1 after R1=0x3C (0x64) -> out_port=0x3C; out_strobe high exactly 1 cycle. IN R3 with in_port=0xA5 (0x7C) -> R3=0xA5.
- Store R0->[R1] (0xE1) with mem_ack after 3 cycles -> mem_req high 3 cycles, mem_we=1, then FETCH. Load with no ack, MEM_TIMEOUT=15 -> mem_req drops after 15 cycles; mem_err=1; R[ra] unchanged.
- BR.SUB R2 (0xB2) at instr_pc=0xFF with R2=0x40 -> redirect_target=0x40. Then RETURN (0xC0) -> redirect_target=0x00 (wrap).
- BR.Z/N with flags_zn=2'b01: 0xA0 -> no redirect pulse; 0xA4 -> redirect pulse.
- Assert rst_n=0 mid-MEM and mid-IMM -> mem_req=0 immediately; registers reset to 0; first byte after release decodes as an opcode.
